mem_bus_arbiter: RTL and testbench

//  Shares one single-ported memory between NUM_REQ requesters (e.g. two cores, or core + loader).

---
 rtl/mem_bus_arbiter_pkg.sv | 25 ++
 rtl/mem_bus_arbiter_if.sv | 36 +++
 rtl/mem_bus_arbiter_rr_pick.sv | 39 +++
 rtl/mem_bus_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Package: mem_bus_arbiter_pkg
// Shared definitions for the memory bus arbiter and its bench: FSM state
// encoding, the requester-count ceiling, the requester index width and a
// one-hot helper.
package mem_bus_arbiter_pkg;

    localparam int MAX_REQ = 4;
    localparam int IDX_W   = 2;
    localparam int DATA_W  = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } arb_state_t;

    function automatic logic [MAX_REQ-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
        logic [MAX_REQ-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Interface: mem_bus_arbiter_if
// Bundles the requester buses and the memory macro port of the arbiter.
//   req/req_we/req_lock   per-requester request, write flag, lock request
//   req_addr/req_wdata    requester i at [32*i +: 32]
//   gnt/resp_valid        one-hot single-cycle pulses back to requesters
//   resp_rdata            read data, valid with resp_valid of a read
//   mem_address/mem_data_out/mem_we/mem_data_in   memory macro side
// Modports: slave = arbiter view, master = requesters + memory view.
interface mem_bus_arbiter_if
    import mem_bus_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        req_we;
    logic [NUM_REQ-1:0]        req_lock;
    logic [NUM_REQ*DATA_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        resp_valid;
    logic [DATA_W-1:0]         resp_rdata;
    logic [DATA_W-1:0]         mem_address;
    logic [DATA_W-1:0]         mem_data_out;
    logic                      mem_we;
    logic [DATA_W-1:0]         mem_data_in;

    modport slave (
        input  req, req_we, req_lock, req_addr, req_wdata, mem_data_in,
        output gnt, resp_valid, resp_rdata, mem_address, mem_data_out, mem_we
    );

    modport master (
        output req, req_we, req_lock, req_addr, req_wdata, mem_data_in,
        input  gnt, resp_valid, resp_rdata, mem_address, mem_data_out, mem_we
    );
endinterface

// File: rtl/mem_bus_arbiter_rr_pick.sv
// Module: rr_pick
// Combinational round-robin selector. Searches the masked request vector
// starting at rr_ptr and wrapping modulo N; returns the first hit.
//   req     in   N      request vector
//   mask    in   N      requesters eligible this cycle
//   rr_ptr  in   IDX_W  search start
//   valid   out  1      some eligible requester found
//   idx     out  IDX_W  index of the winner
module rr_pick
    import mem_bus_arbiter_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0]     req,
    input  logic [N-1:0]     mask,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    logic [MAX_REQ-1:0] cand;
    int                 pos;

    always_comb begin
        cand  = MAX_REQ'(req & mask);
        valid = 1'b0;
        idx   = '0;
        pos   = 0;
        for (int k = 0; k < N; k++) begin
            pos = int'(rr_ptr) + k;
            if (pos >= N) pos = pos - N;
            if (!valid && cand[IDX_W'(pos)]) begin
                valid = 1'b1;
                idx   = IDX_W'(pos);
            end
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Module: mem_bus_arbiter
// Round-robin arbiter sharing one single-ported memory between NUM_REQ
// requesters, one transaction in flight, fixed read latency MEM_LATENCY.
//   clk    in  rising-edge clock
//   reset  in  asynchronous active-high reset
//   bus    slave modport of mem_bus_arbiter_if (requester + memory buses)
// Optional feature: define ARB_LOCK_EN to let a requester holding req_lock
// keep the bus across consecutive transactions (atomic read-modify-write).
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int MEM_LATENCY = 1
) (
    input  logic               clk,
    input  logic               reset,
    mem_bus_arbiter_if.slave   bus
);

    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    arb_state_t                      state_q, state_d;
    logic [IDX_W-1:0]                rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]                idx_q, idx_d;
    logic                            we_q, we_d;
    logic [CNT_W-1:0]                cnt_q, cnt_d;
    logic [NUM_REQ-1:0]              gnt_q, gnt_d;
    logic [NUM_REQ-1:0]              resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0]               resp_rdata_q, resp_rdata_d;
    // The registered memory-side outputs double as the latched address and
    // write data: they hold their value from ACCESS through WAIT.
    logic [DATA_W-1:0]               mem_address_q, mem_address_d;
    logic [DATA_W-1:0]               mem_data_out_q, mem_data_out_d;
    logic                            mem_we_q, mem_we_d;

    logic [MAX_REQ-1:0][DATA_W-1:0]  addr_arr, wdata_arr;
    logic [MAX_REQ-1:0]              we_x;
    logic [NUM_REQ-1:0]              pick_mask;
    logic                            pick_valid;
    logic [IDX_W-1:0]                pick_idx;
    logic                            lock_hold;

    assign addr_arr  = (MAX_REQ*DATA_W)'(bus.req_addr);
    assign wdata_arr = (MAX_REQ*DATA_W)'(bus.req_wdata);
    assign we_x      = MAX_REQ'(bus.req_we);

`ifdef ARB_LOCK_EN
    logic               lock_own_q, lock_own_d;
    logic [IDX_W-1:0]   lock_idx_q, lock_idx_d;
    logic [MAX_REQ-1:0] req_x, lock_x;

    assign req_x     = MAX_REQ'(bus.req);
    assign lock_x    = MAX_REQ'(bus.req_lock);
    // Lock survives only while its owner keeps both req and req_lock high.
    assign lock_hold = lock_own_q && req_x[lock_idx_q] && lock_x[lock_idx_q];
    assign pick_mask = lock_hold ? NUM_REQ'(idx_onehot(lock_idx_q)) : '1;
`else
    logic unused_req_lock;
    assign unused_req_lock = ^bus.req_lock;
    assign lock_hold       = 1'b0;
    assign pick_mask       = '1;
`endif

    rr_pick #(.N(NUM_REQ)) u_rr_pick (
        .req    (bus.req),
        .mask   (pick_mask),
        .rr_ptr (rr_ptr_q),
        .valid  (pick_valid),
        .idx    (pick_idx)
    );

    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        idx_d          = idx_q;
        we_d           = we_q;
        cnt_d          = cnt_q;
        resp_rdata_d   = resp_rdata_q;
        mem_address_d  = mem_address_q;
        mem_data_out_d = mem_data_out_q;
        gnt_d          = '0;
        resp_valid_d   = '0;
        mem_we_d       = 1'b0;
`ifdef ARB_LOCK_EN
        lock_own_d     = lock_own_q;
        lock_idx_d     = lock_idx_q;
`endif
        case (state_q)
            ST_IDLE: begin
                mem_address_d  = '0;
                mem_data_out_d = '0;
`ifdef ARB_LOCK_EN
                if (lock_own_q && !lock_hold) lock_own_d = 1'b0;
`endif
                if (pick_valid) begin
                    state_d        = ST_ACCESS;
                    idx_d          = pick_idx;
                    we_d           = we_x[pick_idx];
                    gnt_d          = NUM_REQ'(idx_onehot(pick_idx));
                    mem_address_d  = addr_arr[pick_idx];
                    mem_data_out_d = wdata_arr[pick_idx];
                    mem_we_d       = we_x[pick_idx];
                    if (!lock_hold)
                        rr_ptr_d = (int'(pick_idx) == NUM_REQ - 1) ? '0 : pick_idx + IDX_W'(1);
`ifdef ARB_LOCK_EN
                    if (lock_x[pick_idx]) begin
                        lock_own_d = 1'b1;
                        lock_idx_d = pick_idx;
                    end
`endif
                end
            end
            ST_ACCESS: begin
                if (we_q) begin
                    state_d        = ST_RESP;
                    resp_valid_d   = NUM_REQ'(idx_onehot(idx_q));
                    mem_address_d  = '0;
                    mem_data_out_d = '0;
                end else begin
                    state_d = ST_WAIT;
                    cnt_d   = CNT_W'(MEM_LATENCY - 1);
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d        = ST_RESP;
                    resp_rdata_d   = bus.mem_data_in;
                    resp_valid_d   = NUM_REQ'(idx_onehot(idx_q));
                    mem_address_d  = '0;
                    mem_data_out_d = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            rr_ptr_q       <= '0;
            idx_q          <= '0;
            we_q           <= 1'b0;
            cnt_q          <= '0;
            gnt_q          <= '0;
            resp_valid_q   <= '0;
            resp_rdata_q   <= '0;
            mem_address_q  <= '0;
            mem_data_out_q <= '0;
            mem_we_q       <= 1'b0;
`ifdef ARB_LOCK_EN
            lock_own_q     <= 1'b0;
            lock_idx_q     <= '0;
`endif
        end else begin
            state_q        <= state_d;
            rr_ptr_q       <= rr_ptr_d;
            idx_q          <= idx_d;
            we_q           <= we_d;
            cnt_q          <= cnt_d;
            gnt_q          <= gnt_d;
            resp_valid_q   <= resp_valid_d;
            resp_rdata_q   <= resp_rdata_d;
            mem_address_q  <= mem_address_d;
            mem_data_out_q <= mem_data_out_d;
            mem_we_q       <= mem_we_d;
`ifdef ARB_LOCK_EN
            lock_own_q     <= lock_own_d;
            lock_idx_q     <= lock_idx_d;
`endif
        end
    end

    assign bus.gnt          = gnt_q;
    assign bus.resp_valid   = resp_valid_q;
    assign bus.resp_rdata   = resp_rdata_q;
    assign bus.mem_address  = mem_address_q;
    assign bus.mem_data_out = mem_data_out_q;
    assign bus.mem_we       = mem_we_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: two instances (MEM_LATENCY 1 and 3, both with
// two requesters) driven by directed stimulus with hand-computed expectations.
module tb_mem_bus_arbiter;
    import mem_bus_arbiter_pkg::*;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    mem_bus_arbiter_if #(.NUM_REQ(2)) bus1 ();
    mem_bus_arbiter_if #(.NUM_REQ(2)) bus3 ();

    mem_bus_arbiter #(.NUM_REQ(2), .MEM_LATENCY(1)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    mem_bus_arbiter #(.NUM_REQ(2), .MEM_LATENCY(3)) u_dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus3)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        reset          = 1'b1;
        bus1.req       = 2'b11;
        bus1.req_we    = 2'b11;
        bus1.req_addr  = {32'h0000_0020, 32'h0000_0010};
        bus1.req_wdata = {32'h2222_2222, 32'h1111_1111};
        bus3.req       = 2'b11;
        repeat (2) @(negedge clk);
        n_checks++; if (bus1.gnt !== 2'b00) begin n_errors++; $display("FAIL reset_gnt: got %0h expected 0", bus1.gnt); end
        n_checks++; if (bus1.resp_valid !== 2'b00) begin n_errors++; $display("FAIL reset_resp_valid: got %0h expected 0", bus1.resp_valid); end
        n_checks++; if (bus1.mem_we !== 1'b0) begin n_errors++; $display("FAIL reset_mem_we: got %0h expected 0", bus1.mem_we); end
        n_checks++; if (bus1.mem_address !== 32'h0) begin n_errors++; $display("FAIL reset_mem_address: got %0h expected 0", bus1.mem_address); end
        n_checks++; if (bus1.mem_data_out !== 32'h0) begin n_errors++; $display("FAIL reset_mem_data_out: got %0h expected 0", bus1.mem_data_out); end
        n_checks++; if (bus1.resp_rdata !== 32'h0) begin n_errors++; $display("FAIL reset_resp_rdata: got %0h expected 0", bus1.resp_rdata); end
        n_checks++; if (bus3.gnt !== 2'b00) begin n_errors++; $display("FAIL reset_gnt3: got %0h expected 0", bus3.gnt); end
        bus1.req    = 2'b00;
        bus1.req_we = 2'b00;
        bus3.req    = 2'b00;
        reset       = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (bus1.gnt !== 2'b00) begin n_errors++; $display("FAIL reset_idle_gnt: got %0h expected 0", bus1.gnt); end
    endtask

    task automatic test_single_read();
        logic [1:0]  exp_gnt, exp_rv;
        logic [31:0] exp_addr;
        @(negedge clk);
        bus1.req_addr[31:0] = 32'h0000_0040;
        bus1.req_we[0]      = 1'b0;
        bus1.req[0]         = 1'b1;
        bus1.mem_data_in    = 32'h0BAD_0BAD;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            bus1.mem_data_in = (k == 2) ? 32'hDEAD_BEEF : 32'h0BAD_0BAD;
            if (k == 1) bus1.req[0] = 1'b0;
            @(negedge clk);
            exp_gnt  = (k == 1) ? 2'b01 : 2'b00;
            exp_addr = (k <= 2) ? 32'h0000_0040 : 32'h0;
            exp_rv   = (k == 3) ? 2'b01 : 2'b00;
            n_checks++; if (bus1.gnt !== exp_gnt) begin n_errors++; $display("FAIL rd_gnt c%0d: got %0h expected %0h", k, bus1.gnt, exp_gnt); end
            n_checks++; if (bus1.mem_address !== exp_addr) begin n_errors++; $display("FAIL rd_addr c%0d: got %0h expected %0h", k, bus1.mem_address, exp_addr); end
            n_checks++; if (bus1.resp_valid !== exp_rv) begin n_errors++; $display("FAIL rd_resp_valid c%0d: got %0h expected %0h", k, bus1.resp_valid, exp_rv); end
            n_checks++; if (bus1.mem_we !== 1'b0) begin n_errors++; $display("FAIL rd_mem_we c%0d: got %0h expected 0", k, bus1.mem_we); end
            if (k == 3) begin
                n_checks++; if (bus1.resp_rdata !== 32'hDEAD_BEEF) begin n_errors++; $display("FAIL rd_rdata: got %0h expected deadbeef", bus1.resp_rdata); end
            end
        end
    endtask

    task automatic test_single_write();
        logic [1:0]  exp_gnt, exp_rv;
        logic [31:0] exp_addr, exp_dout;
        logic        exp_we;
        @(negedge clk);
        bus1.req_addr[63:32]  = 32'h0000_0100;
        bus1.req_wdata[63:32] = 32'h1234_5678;
        bus1.req_we[1]        = 1'b1;
        bus1.req[1]           = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin
                bus1.req[1]    = 1'b0;
                bus1.req_we[1] = 1'b0;
            end
            @(negedge clk);
            exp_we   = (k == 1);
            exp_gnt  = (k == 1) ? 2'b10 : 2'b00;
            exp_rv   = (k == 2) ? 2'b10 : 2'b00;
            exp_addr = (k == 1) ? 32'h0000_0100 : 32'h0;
            exp_dout = (k == 1) ? 32'h1234_5678 : 32'h0;
            n_checks++; if (bus1.gnt !== exp_gnt) begin n_errors++; $display("FAIL wr_gnt c%0d: got %0h expected %0h", k, bus1.gnt, exp_gnt); end
            n_checks++; if (bus1.mem_we !== exp_we) begin n_errors++; $display("FAIL wr_mem_we c%0d: got %0h expected %0h", k, bus1.mem_we, exp_we); end
            n_checks++; if (bus1.mem_address !== exp_addr) begin n_errors++; $display("FAIL wr_addr c%0d: got %0h expected %0h", k, bus1.mem_address, exp_addr); end
            n_checks++; if (bus1.mem_data_out !== exp_dout) begin n_errors++; $display("FAIL wr_dout c%0d: got %0h expected %0h", k, bus1.mem_data_out, exp_dout); end
            n_checks++; if (bus1.resp_valid !== exp_rv) begin n_errors++; $display("FAIL wr_resp_valid c%0d: got %0h expected %0h", k, bus1.resp_valid, exp_rv); end
            if (k == 2) begin
                n_checks++; if (bus1.resp_rdata !== 32'hDEAD_BEEF) begin n_errors++; $display("FAIL wr_rdata_kept: got %0h expected deadbeef", bus1.resp_rdata); end
            end
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_gnt;
        @(negedge clk);
        bus1.req_addr  = {32'h0000_0020, 32'h0000_0010};
        bus1.req_wdata = {32'hBBBB_0001, 32'hAAAA_0000};
        bus1.req_we    = 2'b11;
        bus1.req       = 2'b11;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            exp_gnt = (k % 3 == 1) ? (((k / 3) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
            n_checks++; if (bus1.gnt !== exp_gnt) begin n_errors++; $display("FAIL rr_gnt c%0d: got %0h expected %0h", k, bus1.gnt, exp_gnt); end
            n_checks++; if (bus1.mem_we !== (|exp_gnt)) begin n_errors++; $display("FAIL rr_mem_we c%0d: got %0h expected %0h", k, bus1.mem_we, |exp_gnt); end
            if (exp_gnt == 2'b01) begin
                n_checks++; if (bus1.mem_data_out !== 32'hAAAA_0000) begin n_errors++; $display("FAIL rr_dout0 c%0d: got %0h expected aaaa0000", k, bus1.mem_data_out); end
            end
            if (exp_gnt == 2'b10) begin
                n_checks++; if (bus1.mem_data_out !== 32'hBBBB_0001) begin n_errors++; $display("FAIL rr_dout1 c%0d: got %0h expected bbbb0001", k, bus1.mem_data_out); end
            end
        end
        bus1.req    = 2'b00;
        bus1.req_we = 2'b00;
        @(negedge clk);
        n_checks++; if (bus1.gnt !== 2'b00) begin n_errors++; $display("FAIL rr_withdrawn: got %0h expected 0", bus1.gnt); end
        @(negedge clk);
    endtask

    task automatic test_latency3();
        logic [1:0]  exp_gnt, exp_rv;
        logic [31:0] exp_addr;
        @(negedge clk);
        bus3.req_addr[31:0] = 32'h0000_0080;
        bus3.req_we         = 2'b00;
        bus3.req[0]         = 1'b1;
        bus3.mem_data_in    = 32'h0BAD_0BAD;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            bus3.mem_data_in = (k == 4) ? 32'hCAFE_F00D : 32'h0BAD_0BAD;
            if (k == 1) bus3.req[0] = 1'b0;
            @(negedge clk);
            exp_gnt  = (k == 1) ? 2'b01 : 2'b00;
            exp_addr = (k <= 4) ? 32'h0000_0080 : 32'h0;
            exp_rv   = (k == 5) ? 2'b01 : 2'b00;
            n_checks++; if (bus3.gnt !== exp_gnt) begin n_errors++; $display("FAIL lat3_gnt c%0d: got %0h expected %0h", k, bus3.gnt, exp_gnt); end
            n_checks++; if (bus3.mem_address !== exp_addr) begin n_errors++; $display("FAIL lat3_addr c%0d: got %0h expected %0h", k, bus3.mem_address, exp_addr); end
            n_checks++; if (bus3.resp_valid !== exp_rv) begin n_errors++; $display("FAIL lat3_resp_valid c%0d: got %0h expected %0h", k, bus3.resp_valid, exp_rv); end
            n_checks++; if (bus3.mem_we !== 1'b0) begin n_errors++; $display("FAIL lat3_mem_we c%0d: got %0h expected 0", k, bus3.mem_we); end
            if (k == 5) begin
                n_checks++; if (bus3.resp_rdata !== 32'hCAFE_F00D) begin n_errors++; $display("FAIL lat3_rdata: got %0h expected cafef00d", bus3.resp_rdata); end
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        @(negedge clk);
        bus3.req_addr[31:0] = 32'h0000_0044;
        bus3.req_we         = 2'b00;
        bus3.req[0]         = 1'b1;
        @(posedge clk); #1;
        bus3.req[0] = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (bus3.mem_address !== 32'h0000_0044) begin n_errors++; $display("FAIL rst_pre_addr: got %0h expected 44", bus3.mem_address); end
        #2 reset = 1'b1;
        #1;
        n_checks++; if (bus3.mem_address !== 32'h0) begin n_errors++; $display("FAIL rst_async_addr: got %0h expected 0", bus3.mem_address); end
        n_checks++; if (bus3.resp_rdata !== 32'h0) begin n_errors++; $display("FAIL rst_async_rdata: got %0h expected 0", bus3.resp_rdata); end
        n_checks++; if (bus3.resp_valid !== 2'b00) begin n_errors++; $display("FAIL rst_async_resp_valid: got %0h expected 0", bus3.resp_valid); end
        n_checks++; if (bus3.mem_we !== 1'b0) begin n_errors++; $display("FAIL rst_async_mem_we: got %0h expected 0", bus3.mem_we); end
        @(negedge clk);
        reset = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            n_checks++; if (bus3.resp_valid !== 2'b00) begin n_errors++; $display("FAIL rst_no_resp c%0d: got %0h expected 0", k, bus3.resp_valid); end
            n_checks++; if (bus3.mem_address !== 32'h0) begin n_errors++; $display("FAIL rst_idle_addr c%0d: got %0h expected 0", k, bus3.mem_address); end
        end
        bus3.req_we = 2'b11;
        bus3.req    = 2'b11;
        @(negedge clk);
        n_checks++; if (bus3.gnt !== 2'b01) begin n_errors++; $display("FAIL rst_first_gnt: got %0h expected 1", bus3.gnt); end
        bus3.req    = 2'b00;
        bus3.req_we = 2'b00;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_lock();
        int g [3];
        int exp_g [3];
        int n_gnt;
        int n_resp0;
`ifdef ARB_LOCK_EN
        exp_g = '{0, 0, 1};
`else
        exp_g = '{0, 1, 0};
`endif
        g       = '{-1, -1, -1};
        n_gnt   = 0;
        n_resp0 = 0;
        @(negedge clk);
        bus1.mem_data_in = 32'h1111_2222;
        bus1.req_addr    = {32'h0000_0300, 32'h0000_0200};
        bus1.req_wdata   = {32'h0000_0055, 32'h0};
        bus1.req_we      = 2'b10;
        bus1.req_lock    = 2'b01;
        bus1.req         = 2'b11;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (bus1.gnt[0]) begin
                if (n_gnt < 3) g[n_gnt] = 0;
                n_gnt++;
            end else if (bus1.gnt[1]) begin
                if (n_gnt < 3) g[n_gnt] = 1;
                n_gnt++;
                bus1.req[1] = 1'b0;
            end
            if (bus1.resp_valid[0]) begin
                n_resp0++;
                if (n_resp0 == 1) begin
                    n_checks++; if (bus1.resp_rdata !== 32'h1111_2222) begin n_errors++; $display("FAIL lock_rdata: got %0h expected 11112222", bus1.resp_rdata); end
                    bus1.req_we[0]        = 1'b1;
                    bus1.req_wdata[31:0]  = 32'h0000_0099;
                end else begin
                    bus1.req[0]      = 1'b0;
                    bus1.req_lock[0] = 1'b0;
                end
            end
        end
        n_checks++; if (n_gnt !== 3) begin n_errors++; $display("FAIL lock_gnt_count: got %0d expected 3", n_gnt); end
        n_checks++; if (n_resp0 !== 2) begin n_errors++; $display("FAIL lock_resp0_count: got %0d expected 2", n_resp0); end
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (g[i] !== exp_g[i]) begin n_errors++; $display("FAIL lock_order[%0d]: got %0d expected %0d", i, g[i], exp_g[i]); end
        end
        bus1.req      = 2'b00;
        bus1.req_lock = 2'b00;
        bus1.req_we   = 2'b00;
    endtask

    initial begin
        clk      = 1'b0;
        reset    = 1'b1;
        n_checks = 0;
        n_errors = 0;
        bus1.req = '0; bus1.req_we = '0; bus1.req_lock = '0;
        bus1.req_addr = '0; bus1.req_wdata = '0; bus1.mem_data_in = '0;
        bus3.req = '0; bus3.req_we = '0; bus3.req_lock = '0;
        bus3.req_addr = '0; bus3.req_wdata = '0; bus3.mem_data_in = '0;

        test_reset();
        test_single_read();
        test_single_write();
        test_round_robin();
        test_latency3();
        test_reset_mid_wait();
        test_lock();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
